// File: rtl/adpll_mod_ser.sv
// adpll_mod_ser: CPU-programmable TX serializer. Bytes pushed through the bus
// FIFO are shifted out LSB-first on data_mod as gapless NRZ at div+1 clocks/bit.
module adpll_mod_ser #(
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    input  logic              wstrb,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              data_mod,
    output logic              sym_strobe,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int L  = PW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_n;
    logic          en, idle_lvl, ovf;
    logic [7:0]    div;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [L-1:0]  level;
    logic          empty, full;
    logic          wr_en, push_req, flush, pop, push_ok;
    logic [7:0]    fifo_head;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    div_cnt, div_cnt_n;
    logic          data_mod_n, strobe_n;
    logic          unused_wdata;

    assign unused_wdata = ^{wdata[31:12], wdata[10:8]};

    assign wr_en     = valid & wstrb;
    assign push_req  = wr_en && (address == ADDR_W'(2));
    assign flush     = wr_en && (address == ADDR_W'(5));
    assign empty     = (level == '0);
    assign full      = (level == L'(FIFO_DEPTH));
    assign fifo_head = mem[rd_ptr];
    // a push into a full FIFO still lands if the serializer frees a slot on the same edge
    assign push_ok   = push_req && !flush && (!full || pop);
    assign busy      = (state == SHIFT);

    // bus control registers and the registered handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            div      <= 8'd31;
            idle_lvl <= 1'b0;
            ovf      <= 1'b0;
            ready    <= 1'b0;
        end else begin
            ready <= valid;
            if (wr_en && address == ADDR_W'(0)) en       <= wdata[0];
            if (wr_en && address == ADDR_W'(1)) div      <= wdata[7:0];
            if (wr_en && address == ADDR_W'(4)) idle_lvl <= wdata[0];
            if (wr_en && address == ADDR_W'(3) && wdata[11])
                ovf <= 1'b0;
            else if (push_req && !flush && full && !pop)
                ovf <= 1'b1;
        end
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata[7:0];
    end

    // FIFO pointers and fill level; flush overrides push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + L'(1);
                2'b01:   level <= level - L'(1);
                default: level <= level;
            endcase
        end
    end

    // serializer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            data_mod   <= 1'b0;
            sym_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            div_cnt    <= div_cnt_n;
            data_mod   <= data_mod_n;
            sym_strobe <= strobe_n;
        end
    end

    // next-state: load a byte, count out each bit period, chain bytes without gaps
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        div_cnt_n  = div_cnt;
        data_mod_n = data_mod;
        strobe_n   = 1'b0;
        pop        = 1'b0;
        if (flush) begin
            state_n    = IDLE;
            data_mod_n = idle_lvl;
        end else begin
            case (state)
                IDLE: begin
                    data_mod_n = idle_lvl;
                    if (en && !empty) begin
                        pop        = 1'b1;
                        shreg_n    = fifo_head;
                        bit_cnt_n  = '0;
                        div_cnt_n  = div;
                        data_mod_n = fifo_head[0];
                        strobe_n   = 1'b1;
                        state_n    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt_n = div_cnt - 8'd1;
                    end else if (bit_cnt != 3'd7) begin
                        // shreg is shifted so the bit on the line is always shreg[0]
                        bit_cnt_n  = bit_cnt + 3'd1;
                        shreg_n    = {1'b0, shreg[7:1]};
                        data_mod_n = shreg[1];
                        div_cnt_n  = div;
                        strobe_n   = 1'b1;
                    end else if (en && !empty) begin
                        pop        = 1'b1;
                        shreg_n    = fifo_head;
                        bit_cnt_n  = '0;
                        div_cnt_n  = div;
                        data_mod_n = fifo_head[0];
                        strobe_n   = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        data_mod_n = idle_lvl;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // register read mux, combinational on address
    always_comb begin
        rdata = '0;
        case (address)
            ADDR_W'(0): rdata[0]   = en;
            ADDR_W'(1): rdata[7:0] = div;
            ADDR_W'(2): rdata      = '0;
            ADDR_W'(3): begin
                rdata[L-1:0] = level;
                rdata[8]     = empty;
                rdata[9]     = full;
                rdata[10]    = busy;
                rdata[11]    = ovf;
            end
            ADDR_W'(4): rdata[0]   = idle_lvl;
            ADDR_W'(5): rdata      = '0;
            default:    rdata      = '1;
        endcase
    end

endmodule

// File: tb/tb_adpll_mod_ser.sv
// tb_adpll_mod_ser: register table plus serializer sequences; expected bits are
// queued when bytes are pushed and checked on every sym_strobe.
module tb_adpll_mod_ser;

    logic        clk, rst, valid, wstrb;
    logic [4:0]  address;
    logic [31:0] wdata, rdata;
    logic        ready, data_mod, sym_strobe, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_strobe = 0;
    int busy_cnt = 0;
    int push_cyc = 0;
    int strobe_times[$];
    logic exp_q[$];

    typedef struct {
        bit          do_wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[15];

    adpll_mod_ser #(.ADDR_W(5), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .data_mod(data_mod),
        .sym_strobe(sym_strobe), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor, sampled 1 ns after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (sym_strobe) begin
            n_strobe++;
            strobe_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
            end else begin
                check("serial_bit", {31'b0, data_mod}, {31'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        if (clk) @(negedge clk);
        valid = 1'b1; wstrb = 1'b1; address = a; wdata = d;
        @(negedge clk);
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [4:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(nm, rdata, exp);
    endtask

    task automatic push(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) exp_q.push_back(b[i]);
        bus_wr(5'd2, {24'b0, b});
        push_cyc = cyc;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({nm, "_queue_end"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_strobes(input string nm, input int target, input int maxc);
        int k = 0;
        while (n_strobe < target && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_strobe_wait"}, {31'b0, n_strobe >= target}, 32'd1);
    endtask

    initial begin
        int s0, n0, bad;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n0, bad;
        rst = 1'b1; valid = 1'b0; wstrb = 1'b0; address = '0; wdata = '0;

        tbl[0]  = '{1'b0, 5'd0,  32'h0,        5'd3,  32'h100};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd0,  32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd1,  32'd31};
        tbl[3]  = '{1'b1, 5'd9,  32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        5'd1,  32'd31};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        5'd0,  32'h0};
        tbl[6]  = '{1'b1, 5'd1,  32'h1A5,      5'd1,  32'hA5};
        tbl[7]  = '{1'b1, 5'd0,  32'hFE,       5'd0,  32'h0};
        tbl[8]  = '{1'b1, 5'd4,  32'h3,        5'd4,  32'h1};
        tbl[9]  = '{1'b1, 5'd4,  32'h0,        5'd4,  32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd2,  32'h0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        5'd5,  32'h0};
        tbl[12] = '{1'b0, 5'd0,  32'h0,        5'd31, 32'hFFFFFFFF};
        tbl[13] = '{1'b1, 5'd1,  32'd31,       5'd1,  32'd31};
        tbl[14] = '{1'b0, 5'd0,  32'h0,        5'd6,  32'hFFFFFFFF};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_data_mod", {31'b0, data_mod}, 32'd0);
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_strobe", {31'b0, sym_strobe}, 32'd0);
        rd_check("rst_status", 5'd3, 32'h100);
        @(negedge clk);
        rst = 1'b0;

        // register table
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].do_wr) bus_wr(tbl[i].wa, tbl[i].wd);
            rd_check($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].exp);
        end

        // ready is a one-cycle registered copy of valid
        bus_wr(5'd1, 32'd3);
        check("ready_hi", {31'b0, ready}, 32'd1);
        @(negedge clk);
        check("ready_lo", {31'b0, ready}, 32'd0);

        // A5 at div=3
        bus_wr(5'd0, 32'd1);
        s0 = strobe_times.size();
        push(8'hA5, 8);
        wait_done("a5", 200);
        check("a5_strobes", strobe_times.size() - s0, 32'd8);
        check("a5_latency", strobe_times[s0], push_cyc + 1);
        bad = 0;
        for (int i = 1; i < 8; i++) if (strobe_times[s0+i] - strobe_times[s0+i-1] != 4) bad++;
        check("a5_period", bad, 32'd0);
        check("a5_idle", {31'b0, data_mod}, 32'd0);

        // two bytes back-to-back at div=0
        bus_wr(5'd1, 32'd0);
        s0 = strobe_times.size();
        busy_cnt = 0;
        push(8'h0F, 8);
        push(8'hF0, 8);
        wait_done("b2b", 100);
        check("b2b_strobes", strobe_times.size() - s0, 32'd16);
        bad = 0;
        for (int i = 1; i < 16; i++) if (strobe_times[s0+i] - strobe_times[s0+i-1] != 1) bad++;
        check("b2b_gapless", bad, 32'd0);
        check("b2b_busy_cycles", busy_cnt, 32'd16);

        // overflow with en=0
        bus_wr(5'd0, 32'd0);
        for (int i = 0; i < 9; i++) push(8'(i + 1), 0);
        rd_check("ovf_status", 5'd3, 32'hA08);
        bus_wr(5'd3, 32'h800);
        rd_check("ovf_clear", 5'd3, 32'h208);
        bus_wr(5'd5, 32'd0);
        rd_check("ovf_flush", 5'd3, 32'h100);

        // clear en mid-byte
        bus_wr(5'd1, 32'd7);
        bus_wr(5'd0, 32'd1);
        n0 = n_strobe;
        push(8'h3C, 8);
        push(8'h96, 0);
        wait_strobes("en_clr", n0 + 4, 100);
        bus_wr(5'd0, 32'd0);
        wait_done("en_clr", 200);
        check("en_clr_strobes", n_strobe - n0, 32'd8);
        rd_check("en_clr_status", 5'd3, 32'h001);
        bus_wr(5'd5, 32'd0);
        rd_check("en_clr_flush", 5'd3, 32'h100);

        // div rewritten during bit 0
        bus_wr(5'd0, 32'd1);
        s0 = strobe_times.size();
        n0 = n_strobe;
        push(8'h01, 8);
        wait_strobes("div_chg", n0 + 1, 50);
        bus_wr(5'd1, 32'd1);
        wait_done("div_chg", 100);
        bad = 0;
        for (int i = 1; i < 8; i++)
            if (strobe_times[s0+i] - strobe_times[s0+i-1] != ((i == 1) ? 8 : 2)) bad++;
        check("div_chg_period", bad, 32'd0);

        // flush during bit 5 with idle level high
        bus_wr(5'd4, 32'd1);
        @(negedge clk);
        check("idle_hi", {31'b0, data_mod}, 32'd1);
        bus_wr(5'd1, 32'd3);
        n0 = n_strobe;
        push(8'h55, 6);
        push(8'hAA, 0);
        wait_strobes("flush", n0 + 6, 100);
        bus_wr(5'd5, 32'd0);
        check("flush_data_mod", {31'b0, data_mod}, 32'd1);
        check("flush_busy", {31'b0, busy}, 32'd0);
        rd_check("flush_status", 5'd3, 32'h100);
        repeat (20) @(negedge clk);
        check("flush_no_strobes", n_strobe - n0, 32'd6);
        check("flush_queue", exp_q.size(), 32'd0);
        bus_wr(5'd4, 32'd0);

        // asynchronous reset mid-byte
        @(negedge clk);
        n0 = n_strobe;
        push(8'hC3, 2);
        wait_strobes("arst", n0 + 2, 50);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_data_mod", {31'b0, data_mod}, 32'd0);
        check("arst_strobe", {31'b0, sym_strobe}, 32'd0);
        rd_check("arst_status", 5'd3, 32'h100);
        rd_check("arst_div", 5'd1, 32'd31);
        check("arst_queue", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        rd_check("arst_en", 5'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
